// File: rtl/ov7670_capture_scaled_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_pkg
// Shared definitions for the scaled OV7670 capture path:
//   - pixel format selector codes (rgbmode input)
//   - capture state machine encoding
//   - default geometry and the decimation factors derived from it
//   - pack_pixel: converts a camera byte pair into a packed {R,G,B} word
// ---------------------------------------------------------------------------
package ov7670_pkg;

   localparam logic [1:0] C_MODE_RGB444 = 2'b00;
   localparam logic [1:0] C_MODE_RGB565 = 2'b01;
   localparam logic [1:0] C_MODE_RGB555 = 2'b10;
   localparam logic [1:0] C_MODE_YUV    = 2'b11;

   typedef enum logic [1:0] {
      ST_WAIT_VS    = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_CAPTURE    = 2'd2
   } state_t;

   localparam int C_DEF_SRC_COLS = 640;
   localparam int C_DEF_SRC_ROWS = 480;
   localparam int C_DEF_IMG_COLS = 80;
   localparam int C_DEF_IMG_ROWS = 60;

   function automatic int decim_factor(input int src, input int img);
      return src / img;
   endfunction

   localparam int C_DEF_COL_FACTOR = decim_factor(C_DEF_SRC_COLS, C_DEF_IMG_COLS);
   localparam int C_DEF_ROW_FACTOR = decim_factor(C_DEF_SRC_ROWS, C_DEF_IMG_ROWS);

   // Each channel is first MSB-justified into 8 bits (zero LSBs), then the
   // top nb_* bits are kept. A stored width larger than the source channel
   // therefore pads with zeros at the LSBs. Result is right-justified in 24b.
   function automatic logic [23:0] pack_pixel(
      input logic [1:0] mode,
      input logic [7:0] byte0,
      input logic [7:0] byte1,
      input int         nb_red,
      input int         nb_green,
      input int         nb_blue
   );
      logic [7:0] red8;
      logic [7:0] green8;
      logic [7:0] blue8;
      // YUV: byte0 is luma, replicated into all three channels
      red8   = byte0;
      green8 = byte0;
      blue8  = byte0;
      case (mode)
         C_MODE_RGB444: begin
            red8   = {byte0[3:0], 4'h0};
            green8 = {byte1[7:4], 4'h0};
            blue8  = {byte1[3:0], 4'h0};
         end
         C_MODE_RGB565: begin
            red8   = {byte0[7:3], 3'b000};
            green8 = {byte0[2:0], byte1[7:5], 2'b00};
            blue8  = {byte1[4:0], 3'b000};
         end
         C_MODE_RGB555: begin
            red8   = {byte0[6:2], 3'b000};
            green8 = {byte0[1:0], byte1[7:5], 3'b000};
            blue8  = {byte1[4:0], 3'b000};
         end
         default: ;
      endcase
      return (24'(red8 >> (8 - nb_red)) << (nb_green + nb_blue))
           | (24'(green8 >> (8 - nb_green)) << nb_blue)
           |  24'(blue8 >> (8 - nb_blue));
   endfunction

endpackage

// File: rtl/ov7670_capture_scaled_sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Three-stage synchroniser for one asynchronous camera signal, with
// rise/fall detection between stage 2 and stage 3.
//   clk   in  system clock
//   rst   in  asynchronous reset, active low
//   din   in  asynchronous input
//   level out synchronised level (stage 2)
//   rise  out one-clk pulse on a 0->1 transition of level
//   fall  out one-clk pulse on a 1->0 transition of level
// ---------------------------------------------------------------------------
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1_reg;
   logic s2_reg;
   logic s3_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
         s3_reg <= 1'b0;
      end else begin
         s1_reg <= din;
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
      end
   end

   assign level = s2_reg;
   assign rise  = s2_reg & ~s3_reg;
   assign fall  = ~s2_reg & s3_reg;

endmodule

// File: rtl/ov7670_capture_scaled.sv
// ---------------------------------------------------------------------------
// ov7670_capture_scaled
// Captures OV7670 pixel data in the system clock domain, converts one of
// four pixel formats to a packed {R,G,B} word and decimates the sensor
// image down to c_img_cols x c_img_rows before writing a frame buffer.
//   clk         in  system clock
//   rst         in  asynchronous reset, active low
//   pclk        in  camera pixel clock (sampled as data)
//   vsync       in  camera vsync, high during vertical blanking
//   href        in  camera line valid
//   data        in  camera data bus [7:0]
//   rgbmode     in  pixel format, latched at frame start
//   addr        out frame buffer write address
//   dout        out packed pixel {red, green, blue}
//   we          out one-clk write strobe
//   frame_done  out one-clk pulse after each captured frame
//   frame_short out last frame wrote fewer than c_img_cols*c_img_rows pixels
//   frame_cnt   out completed frame counter (wraps)
// ---------------------------------------------------------------------------
module ov7670_capture_scaled
   import ov7670_pkg::*;
#(
   parameter int c_src_cols     = C_DEF_SRC_COLS,
   parameter int c_src_rows     = C_DEF_SRC_ROWS,
   parameter int c_img_cols     = C_DEF_IMG_COLS,
   parameter int c_img_rows     = C_DEF_IMG_ROWS,
   parameter int c_nb_img_pxls  = 13,
   parameter int c_nb_buf_red   = 4,
   parameter int c_nb_buf_green = 4,
   parameter int c_nb_buf_blue  = 4,
   parameter int c_nb_buf       = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pclk,
   input  logic                     vsync,
   input  logic                     href,
   input  logic [7:0]               data,
   input  logic [1:0]               rgbmode,
   output logic [c_nb_img_pxls-1:0] addr,
   output logic [c_nb_buf-1:0]      dout,
   output logic                     we,
   output logic                     frame_done,
   output logic                     frame_short,
   output logic [7:0]               frame_cnt
);

   localparam int c_col_factor = decim_factor(c_src_cols, c_img_cols);
   localparam int c_row_factor = decim_factor(c_src_rows, c_img_rows);
   localparam int c_nb_col_ph  = (c_col_factor > 1) ? $clog2(c_col_factor) : 1;
   localparam int c_nb_row_ph  = (c_row_factor > 1) ? $clog2(c_row_factor) : 1;
   localparam int c_nb_src_col = $clog2(c_src_cols + 1);
   localparam int c_nb_src_row = $clog2(c_src_rows + 1);
   localparam int c_nb_cnt     = c_nb_img_pxls + 1;

   localparam logic [c_nb_col_ph-1:0]   c_col_ph_last = c_nb_col_ph'(c_col_factor - 1);
   localparam logic [c_nb_row_ph-1:0]   c_row_ph_last = c_nb_row_ph'(c_row_factor - 1);
   localparam logic [c_nb_src_col-1:0]  c_src_col_lim = c_nb_src_col'(c_src_cols);
   localparam logic [c_nb_src_row-1:0]  c_src_row_lim = c_nb_src_row'(c_src_rows);
   localparam logic [c_nb_cnt-1:0]      c_wr_total    = c_nb_cnt'(c_img_cols * c_img_rows);
   localparam logic [c_nb_img_pxls-1:0] c_addr_last   = c_nb_img_pxls'(c_img_cols * c_img_rows - 1);

   // bit positions in the synchroniser bank
   localparam int c_idx_pclk  = 0;
   localparam int c_idx_href  = 1;
   localparam int c_idx_vsync = 2;

   // ---------------- input synchronisation ----------------
   logic [2:0] cam_in;
   logic [2:0] cam_level;
   logic [2:0] cam_rise;
   logic [2:0] cam_fall;

   assign cam_in = {vsync, href, pclk};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         sync_edge_det u_sync (
            .clk   (clk),
            .rst   (rst),
            .din   (cam_in[gi]),
            .level (cam_level[gi]),
            .rise  (cam_rise[gi]),
            .fall  (cam_fall[gi])
         );
      end
   endgenerate

   logic pclk_re;
   logic href_s2;
   logic href_fall;
   logic vsync_s2;
   logic vsync_rise;
   logic vsync_fall;
   logic sync_unused;

   assign pclk_re     = cam_rise[c_idx_pclk];
   assign href_s2     = cam_level[c_idx_href];
   assign href_fall   = cam_fall[c_idx_href];
   assign vsync_s2    = cam_level[c_idx_vsync];
   assign vsync_rise  = cam_rise[c_idx_vsync];
   assign vsync_fall  = cam_fall[c_idx_vsync];
   assign sync_unused = ^{cam_level[c_idx_pclk], cam_fall[c_idx_pclk], cam_rise[c_idx_href]};

   // data goes through the same two stages so it lines up with pclk_re
   logic [7:0] data_s1_reg;
   logic [7:0] data_s2_reg;

   // ---------------- capture state machine ----------------
   state_t state_reg;
   state_t state_next;
   logic   frame_start;
   logic   frame_end;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= ST_WAIT_VS;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state_reg)
         ST_WAIT_VS: begin
            if (vsync_s2) state_next = ST_WAIT_FRAME;
         end
         ST_WAIT_FRAME: begin
            if (vsync_fall) begin
               state_next  = ST_CAPTURE;
               frame_start = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (vsync_rise) begin
               state_next = ST_WAIT_FRAME;
               frame_end  = 1'b1;
            end
         end
         default: state_next = ST_WAIT_VS;
      endcase
   end

   // ---------------- pixel assembly and decimation ----------------
   logic                     capturing;
   logic                     pix_done;
   logic                     keep_pix;
   logic                     byte_ph_reg;
   logic [7:0]               byte0_reg;
   logic [1:0]               mode_reg;
   logic [c_nb_col_ph-1:0]   col_ph_reg;
   logic [c_nb_row_ph-1:0]   row_ph_reg;
   logic [c_nb_src_col-1:0]  src_col_reg;
   logic [c_nb_src_row-1:0]  src_row_reg;
   logic [c_nb_cnt-1:0]      wr_cnt_reg;
   logic [c_nb_img_pxls-1:0] addr_reg;
   logic [c_nb_buf-1:0]      dout_reg;
   logic                     we_reg;
   logic                     frame_end_pend_reg;
   logic                     frame_done_reg;
   logic                     frame_short_reg;
   logic [7:0]               frame_cnt_reg;

   assign capturing = (state_reg == ST_CAPTURE);
   assign pix_done  = pclk_re & href_s2 & byte_ph_reg;
   assign keep_pix  = capturing & pix_done
                    & (col_ph_reg == '0) & (row_ph_reg == '0)
                    & (src_col_reg < c_src_col_lim) & (src_row_reg < c_src_row_lim)
                    & (wr_cnt_reg < c_wr_total);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_s1_reg        <= '0;
         data_s2_reg        <= '0;
         byte_ph_reg        <= 1'b0;
         byte0_reg          <= '0;
         mode_reg           <= C_MODE_RGB444;
         col_ph_reg         <= '0;
         row_ph_reg         <= '0;
         src_col_reg        <= '0;
         src_row_reg        <= '0;
         wr_cnt_reg         <= '0;
         addr_reg           <= '0;
         dout_reg           <= '0;
         we_reg             <= 1'b0;
         frame_end_pend_reg <= 1'b0;
         frame_done_reg     <= 1'b0;
         frame_short_reg    <= 1'b0;
         frame_cnt_reg      <= '0;
      end else begin
         data_s1_reg <= data;
         data_s2_reg <= data_s1_reg;

         // byte phase: 0 = expecting byte0, 1 = expecting byte1
         if (!href_s2)     byte_ph_reg <= 1'b0;
         else if (pclk_re) byte_ph_reg <= ~byte_ph_reg;

         if (pclk_re && href_s2 && !byte_ph_reg) byte0_reg <= data_s2_reg;

         if (frame_start) mode_reg <= rgbmode;

         // horizontal position within the current line
         if (frame_start || !href_s2) begin
            col_ph_reg  <= '0;
            src_col_reg <= '0;
         end else if (pix_done) begin
            col_ph_reg <= (col_ph_reg == c_col_ph_last) ? '0 : col_ph_reg + c_nb_col_ph'(1);
            if (src_col_reg != c_src_col_lim) src_col_reg <= src_col_reg + c_nb_src_col'(1);
         end

         // vertical position within the current frame
         if (frame_start) begin
            row_ph_reg  <= '0;
            src_row_reg <= '0;
         end else if (capturing && href_fall) begin
            row_ph_reg <= (row_ph_reg == c_row_ph_last) ? '0 : row_ph_reg + c_nb_row_ph'(1);
            if (src_row_reg != c_src_row_lim) src_row_reg <= src_row_reg + c_nb_src_row'(1);
         end

         // write port: strobe and data one clk after the completing pclk_re
         we_reg <= keep_pix;
         if (keep_pix) begin
            dout_reg <= c_nb_buf'(pack_pixel(mode_reg, byte0_reg, data_s2_reg,
                                             c_nb_buf_red, c_nb_buf_green, c_nb_buf_blue));
         end

         if (frame_start) begin
            wr_cnt_reg <= '0;
            addr_reg   <= '0;
         end else begin
            if (keep_pix) wr_cnt_reg <= wr_cnt_reg + c_nb_cnt'(1);
            if (we_reg && (addr_reg != c_addr_last)) addr_reg <= addr_reg + c_nb_img_pxls'(1);
         end

         // frame end is reported one clk late so a write coincident with
         // the vsync edge is both strobed and counted before frame_done
         frame_end_pend_reg <= frame_end;
         frame_done_reg     <= frame_end_pend_reg;
         if (frame_end_pend_reg) begin
            frame_cnt_reg   <= frame_cnt_reg + 8'd1;
            frame_short_reg <= (wr_cnt_reg != c_wr_total);
         end
      end
   end

   assign addr        = addr_reg;
   assign dout        = dout_reg;
   assign we          = we_reg;
   assign frame_done  = frame_done_reg;
   assign frame_short = frame_short_reg;
   assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_ov7670_capture_scaled.sv
// ---------------------------------------------------------------------------
// tb_ov7670_capture_scaled
// Directed bench for a reduced sensor geometry (16x12 -> 4x6, factors 4/2,
// 24 stored pixels) so that complete frames stay short. A camera model
// drives pclk/href/vsync/data (data changes while pclk is low); a write
// monitor checks every write strobe against the expected address and pixel.
// ---------------------------------------------------------------------------
module tb_ov7670_capture_scaled;

   localparam int SRC_COLS = 16;
   localparam int SRC_ROWS = 12;
   localparam int IMG_COLS = 4;
   localparam int IMG_ROWS = 6;

   logic        clk;
   logic        rst;
   logic        pclk;
   logic        vsync;
   logic        href;
   logic [7:0]  data;
   logic [1:0]  rgbmode;
   logic [4:0]  addr;
   logic [11:0] dout;
   logic        we;
   logic        frame_done;
   logic        frame_short;
   logic [7:0]  frame_cnt;

   ov7670_capture_scaled #(
      .c_src_cols     (SRC_COLS),
      .c_src_rows     (SRC_ROWS),
      .c_img_cols     (IMG_COLS),
      .c_img_rows     (IMG_ROWS),
      .c_nb_img_pxls  (5),
      .c_nb_buf_red   (4),
      .c_nb_buf_green (4),
      .c_nb_buf_blue  (4),
      .c_nb_buf       (12)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pclk        (pclk),
      .vsync       (vsync),
      .href        (href),
      .data        (data),
      .rgbmode     (rgbmode),
      .addr        (addr),
      .dout        (dout),
      .we          (we),
      .frame_done  (frame_done),
      .frame_short (frame_short),
      .frame_cnt   (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   int          frame_writes = 0;
   int          done_pulses  = 0;
   int          pat          = 0;
   int          switch_line  = -1;
   logic [1:0]  mode_after   = 2'b00;
   logic [7:0]  b0_const     = 8'h00;
   logic [7:0]  b1_const     = 8'h00;
   logic [11:0] exp_dout     = 12'h000;
   int          done_before;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // positional pattern: R = source column, G = source row, B = 0
   function automatic logic [11:0] pos_expect(input int k);
      logic [3:0] col;
      logic [3:0] row;
      col = 4'((k % IMG_COLS) * 4);
      row = 4'((k / IMG_COLS) * 2);
      return {col, row, 4'h0};
   endfunction

   // write monitor, sampled on the falling clock edge
   always @(negedge clk) begin
      if (we === 1'b1) begin
         $display("wr   addr=%0d dout=0x%03h", addr, dout);
         check("wr_addr", 32'(addr), 32'(frame_writes));
         check("wr_dout", 32'(dout), 32'((pat == 1) ? pos_expect(frame_writes) : exp_dout));
         frame_writes++;
      end
      if (frame_done === 1'b1) done_pulses++;
   end

   // ---------------- camera model ----------------
   task automatic cam_byte(input logic [7:0] b);
      pclk = 1'b0; data = b; #20;
      pclk = 1'b1; #20;
   endtask

   task automatic cam_blank(input int n);
      for (int i = 0; i < n; i++) begin
         pclk = 1'b0; #20;
         pclk = 1'b1; #20;
      end
   endtask

   task automatic cam_line(input int row);
      logic [7:0] b0;
      logic [7:0] b1;
      href = 1'b1;
      for (int c = 0; c < SRC_COLS; c++) begin
         if (pat == 1) begin
            b0 = 8'(c);
            b1 = {4'(row), 4'h0};
         end else begin
            b0 = b0_const;
            b1 = b1_const;
         end
         cam_byte(b0);
         cam_byte(b1);
      end
      pclk = 1'b0; href = 1'b0; #20;
      pclk = 1'b1; #20;
      cam_blank(3);
   endtask

   task automatic cam_frame(input int nlines);
      vsync = 1'b1; cam_blank(4);
      vsync = 1'b0; cam_blank(4);
      for (int r = 0; r < nlines; r++) begin
         if (r == switch_line) rgbmode = mode_after;
         cam_line(r);
      end
      vsync = 1'b1; cam_blank(4);
   endtask

   task automatic frame_checks(input string tag, input int writes, input int short_exp,
                               input int cnt_exp, input int addr_exp);
      $display("frame %s writes=%0d short=%0b cnt=%0d addr=%0d", tag, frame_writes, frame_short, frame_cnt, addr);
      check({tag, "_writes"}, 32'(frame_writes), 32'(writes));
      check({tag, "_done"},   32'(done_pulses - done_before), 32'd1);
      check({tag, "_short"},  32'(frame_short), 32'(short_exp));
      check({tag, "_cnt"},    32'(frame_cnt), 32'(cnt_exp));
      check({tag, "_addr"},   32'(addr), 32'(addr_exp));
   endtask

   task automatic start_frame(input logic [1:0] mode, input int p, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [11:0] e);
      rgbmode      = mode;
      pat          = p;
      b0_const     = b0;
      b1_const     = b1;
      exp_dout     = e;
      frame_writes = 0;
      done_before  = done_pulses;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b0; pclk = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00; rgbmode = 2'b00;
      #42;
      $display("reset asserted");
      check("rst_addr",  32'(addr), 32'd0);
      check("rst_dout",  32'(dout), 32'd0);
      check("rst_we",    32'(we), 32'd0);
      check("rst_done",  32'(frame_done), 32'd0);
      check("rst_short", 32'(frame_short), 32'd0);
      check("rst_cnt",   32'(frame_cnt), 32'd0);
      rst = 1'b1;
      #40;

      // A: RGB444 constant 0x0A,0x5C
      start_frame(2'b00, 0, 8'h0A, 8'h5C, 12'hA5C);
      cam_frame(SRC_ROWS);
      frame_checks("rgb444", 24, 0, 1, 23);

      // B: RGB565 0xF8,0x1F -> 0xF0F
      start_frame(2'b01, 0, 8'hF8, 8'h1F, 12'hF0F);
      cam_frame(SRC_ROWS);
      frame_checks("rgb565", 24, 0, 2, 23);

      // C: RGB444 positional pattern, only col%4=0 / row%2=0 stored
      start_frame(2'b00, 1, 8'h00, 8'h00, 12'h000);
      cam_frame(SRC_ROWS);
      frame_checks("decim", 24, 0, 3, 23);

      // D: YUV Y=0x9C, rgbmode switched to RGB444 mid-frame (no effect)
      start_frame(2'b11, 0, 8'h9C, 8'h80, 12'h999);
      switch_line = 5;
      mode_after  = 2'b00;
      cam_frame(SRC_ROWS);
      switch_line = -1;
      frame_checks("yuv", 24, 0, 4, 23);

      // E: short frame of 6 lines -> rows 0,2,4 stored
      start_frame(2'b00, 0, 8'h0A, 8'h5C, 12'hA5C);
      cam_frame(6);
      frame_checks("short", 12, 1, 5, 12);

      // R: reset after 10 writes, rest of the frame must be ignored
      start_frame(2'b00, 0, 8'h0A, 8'h5C, 12'hA5C);
      fork
         cam_frame(SRC_ROWS);
         begin
            for (int t = 0; t < 5000 && frame_writes < 10; t++) #10;
            check("rst_trigger", 32'(frame_writes >= 10), 32'd1);
            rst = 1'b0;
            frame_writes = 0;
            #1;
            $display("reset mid-frame");
            check("mid_addr",  32'(addr), 32'd0);
            check("mid_dout",  32'(dout), 32'd0);
            check("mid_we",    32'(we), 32'd0);
            check("mid_done",  32'(frame_done), 32'd0);
            check("mid_short", 32'(frame_short), 32'd0);
            check("mid_cnt",   32'(frame_cnt), 32'd0);
            #20;
            rst = 1'b1;
         end
      join
      $display("frame after-reset writes=%0d cnt=%0d", frame_writes, frame_cnt);
      check("post_rst_writes", 32'(frame_writes), 32'd0);
      check("post_rst_done",   32'(done_pulses - done_before), 32'd0);
      check("post_rst_cnt",    32'(frame_cnt), 32'd0);

      // G: first full frame after reset
      start_frame(2'b00, 0, 8'h0A, 8'h5C, 12'hA5C);
      cam_frame(SRC_ROWS);
      frame_checks("resume", 24, 0, 1, 23);

      // F: oversized frame (25 lines) -> still exactly 24 writes
      start_frame(2'b01, 0, 8'hF8, 8'h1F, 12'hF0F);
      cam_frame(25);
      frame_checks("long", 24, 0, 2, 23);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
